// File: rtl/pipe_stage_elastic_pkg.sv
// Shared pipeline-stage control types and constants.
// Per-stage payload types live with their stages; only handshake control is common.
package pipes;

  typedef struct packed {
    logic stall;
    logic flush;
  } stage_ctrl_t;

  localparam int OCC_W = 2;

endpackage

// File: rtl/pipe_stage_elastic_slot.sv
// One valid+payload register for the elastic stage.
// Priority: reset > kill > load > drop > hold.
module pipe_stage_slot #(
  parameter int WIDTH          = 64,
  parameter int CLEAR_ON_FLUSH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             kill,
  input  logic             load,
  input  logic             drop,
  input  logic [WIDTH-1:0] load_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (kill) begin
      valid <= 1'b0;
      if (CLEAR_ON_FLUSH != 0) data <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (drop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register with valid/ready handshake, stall, flush,
// optional skid entry and saturating stall/bubble counters.
module pipe_stage_elastic
  import pipes::*;
#(
  parameter int WIDTH          = 64,
  parameter int SKID           = 1,
  parameter int CLEAR_ON_FLUSH = 1,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  stage_ctrl_t      ctrl;
  logic             h_valid;
  logic [WIDTH-1:0] h_data;
  logic             s_valid;
  logic             fire_in;
  logic             fire_out;
  logic             h_load;
  logic             h_drop;
  logic [WIDTH-1:0] h_din;
  logic             bubble;

  assign ctrl      = '{stall: stall, flush: flush};
  assign out_valid = h_valid & ~ctrl.stall & ~ctrl.flush;
  assign out_data  = h_data;
  assign fire_in   = in_valid & in_ready;
  assign fire_out  = out_valid & out_ready;
  // s_valid implies h_valid, so the count never needs an adder
  assign occupancy = {s_valid, h_valid & ~s_valid};

  // Stall zeroes both fires, so no load/drop fires; flush is handled by kill.
  generate
    if (SKID != 0) begin : g_skid
      logic             s_load;
      logic             s_drop;
      logic [WIDTH-1:0] s_data;

      assign in_ready = (~s_valid & ~ctrl.stall) | ctrl.flush;

      always_comb begin
        h_load = 1'b0;
        h_drop = 1'b0;
        h_din  = in_data;
        s_load = 1'b0;
        s_drop = 1'b0;
        if (fire_out && s_valid) begin
          h_load = 1'b1;
          h_din  = s_data;
          s_drop = 1'b1;
        end else if (fire_out) begin
          h_load = fire_in;
          h_drop = ~fire_in;
        end else if (fire_in) begin
          h_load = ~h_valid;
          s_load = h_valid;
        end
      end

      pipe_stage_slot #(.WIDTH(WIDTH), .CLEAR_ON_FLUSH(CLEAR_ON_FLUSH)) u_skid_slot (
        .clk       (clk),
        .reset     (reset),
        .kill      (ctrl.flush),
        .load      (s_load),
        .drop      (s_drop),
        .load_data (in_data),
        .valid     (s_valid),
        .data      (s_data)
      );
    end else begin : g_single
      assign in_ready = ((~h_valid | out_ready) & ~ctrl.stall) | ctrl.flush;
      assign h_load   = fire_in;
      assign h_drop   = fire_out & ~fire_in;
      assign h_din    = in_data;
      assign s_valid  = 1'b0;
    end
  endgenerate

  pipe_stage_slot #(.WIDTH(WIDTH), .CLEAR_ON_FLUSH(CLEAR_ON_FLUSH)) u_head_slot (
    .clk       (clk),
    .reset     (reset),
    .kill      (ctrl.flush),
    .load      (h_load),
    .drop      (h_drop),
    .load_data (h_din),
    .valid     (h_valid),
    .data      (h_data)
  );

  assign bubble = out_ready & ~h_valid & ~ctrl.stall & ~ctrl.flush;

  // Counters stick at all-ones and survive flush
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (ctrl.stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (bubble && !(&bubble_cnt))    bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule
